// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the instruction-memory slave state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } imem_state_e;

endpackage

// File: rtl/ahb_imem_slave.sv
// AHB-Lite read-only slave in front of a 1-cycle synchronous instruction memory.
// Define IMEM_ERR_EN to answer writes, sub-word, misaligned and out-of-range accesses with ERROR.
module ahb_imem_slave
  import ahb_pkg::*;
#(
  parameter int unsigned MEM_AW      = 12,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic              HREADY,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic              mem_cen,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_dout
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  imem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        phase_open;
  logic        addr_valid;
  logic        rd_acc;
  logic        err_acc;
  logic        unused_inputs;

  // Address phases are only sampled while this slave itself is driving HREADYOUT high.
  assign phase_open = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
  assign addr_valid = HSEL && HREADY && phase_open &&
                      ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

`ifdef IMEM_ERR_EN
  logic bad_req;
  assign bad_req = HWRITE || (HSIZE != HSIZE_WORD) || (HADDR[1:0] != 2'b00) ||
                   ((HADDR >> (MEM_AW + 2)) != 32'd0);
  assign rd_acc  = addr_valid && !bad_req;
  assign err_acc = addr_valid && bad_req;
`else
  assign rd_acc  = addr_valid && !HWRITE;
  assign err_acc = 1'b0;
`endif

  // Burst type, size and the byte/upper address bits carry no meaning for this slave.
  assign unused_inputs = ^{HBURST, HSIZE, HADDR};

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    // A pipelined address phase in DATA/ERR2 overrides the fall back to IDLE.
    if (err_acc) begin
      state_d = ST_ERR1;
    end else if (rd_acc) begin
      if (WAIT_LOAD != 4'd0) begin
        state_d = ST_WAIT;
        cnt_d   = WAIT_LOAD;
      end else begin
        state_d = ST_DATA;
      end
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = '0;
    mem_cen   = 1'b1;
    mem_addr  = '0;
    unique case (state_q)
      ST_WAIT: HREADYOUT = 1'b0;
      ST_DATA: HRDATA = mem_dout;
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      ST_ERR2: HRESP = HRESP_ERROR;
      default: ;
    endcase
    if (rd_acc && !HRESET) begin
      mem_cen  = 1'b0;
      mem_addr = HADDR[MEM_AW+1:2];
    end
  end

endmodule

// File: tb/tb_ahb_imem_slave.sv
// Directed bench: three slaves (0, 2 and 3 wait states) on one shared AHB-Lite address bus.
module tb_ahb_imem_slave;
  import ahb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;

  logic        rdy0, resp0, cen0;
  logic        rdy1, resp1, cen1;
  logic        rdy2, resp2, cen2;
  logic [31:0] rdata0, rdata1, rdata2;
  logic [31:0] dout0, dout1, dout2;
  logic [11:0] maddr0, maddr1, maddr2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [11:0] a);
    return {8'hA5, 12'h000, a};
  endfunction

  always @(posedge clk) if (!cen0) dout0 <= mem_val(maddr0);
  always @(posedge clk) if (!cen1) dout1 <= mem_val(maddr1);
  always @(posedge clk) if (!cen2) dout2 <= mem_val(maddr2);

  ahb_imem_slave #(.MEM_AW(12), .WAIT_STATES(0)) u_ws0 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HREADY(rdy0),
    .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0),
    .mem_cen(cen0), .mem_addr(maddr0), .mem_dout(dout0));

  ahb_imem_slave #(.MEM_AW(12), .WAIT_STATES(2)) u_ws2 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HREADY(rdy1),
    .HRDATA(rdata1), .HREADYOUT(rdy1), .HRESP(resp1),
    .mem_cen(cen1), .mem_addr(maddr1), .mem_dout(dout1));

  ahb_imem_slave #(.MEM_AW(12), .WAIT_STATES(3)) u_ws3 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HREADY(rdy2),
    .HRDATA(rdata2), .HREADYOUT(rdy2), .HRESP(resp2),
    .mem_cen(cen2), .mem_addr(maddr2), .mem_dout(dout2));

  task automatic drive(input logic [2:0] sel, input logic [31:0] a, input logic [1:0] tr,
                       input logic wr, input logic [2:0] sz, input logic [2:0] bu);
    hsel = sel; haddr = a; htrans = tr; hwrite = wr; hsize = sz; hburst = bu;
  endtask

  task automatic bus_idle();
    drive(3'b000, 32'h0, HTRANS_IDLE, 1'b0, HSIZE_WORD, HBURST_SINGLE);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(3'b111, 32'h100, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, HBURST_SINGLE);
    repeat (2) @(posedge clk);
    #1;
    nvec++; if (rdy0 !== 1'b1) begin nerr++; $display("FAIL reset_rdy0: got %b expected 1", rdy0); end
    nvec++; if (resp0 !== 1'b0) begin nerr++; $display("FAIL reset_resp0: got %b expected 0", resp0); end
    nvec++; if (rdata0 !== 32'h0) begin nerr++; $display("FAIL reset_rdata0: got %h expected 0", rdata0); end
    nvec++; if (cen0 !== 1'b1) begin nerr++; $display("FAIL reset_cen0: got %b expected 1", cen0); end
    nvec++; if (maddr0 !== 12'h0) begin nerr++; $display("FAIL reset_maddr0: got %h expected 0", maddr0); end
    nvec++; if (rdy1 !== 1'b1) begin nerr++; $display("FAIL reset_rdy1: got %b expected 1", rdy1); end
    nvec++; if (rdy2 !== 1'b1) begin nerr++; $display("FAIL reset_rdy2: got %b expected 1", rdy2); end
    bus_idle();
    #3 rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    drive(3'b001, 32'h100, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, HBURST_SINGLE);
    #1;
    nvec++; if (cen0 !== 1'b0) begin nerr++; $display("FAIL single_cen: got %b expected 0", cen0); end
    nvec++; if (maddr0 !== 12'h040) begin nerr++; $display("FAIL single_maddr: got %h expected 040", maddr0); end
    step();
    bus_idle();
    #1;
    nvec++; if (rdy0 !== 1'b1) begin nerr++; $display("FAIL single_rdy: got %b expected 1", rdy0); end
    nvec++; if (resp0 !== 1'b0) begin nerr++; $display("FAIL single_resp: got %b expected 0", resp0); end
    nvec++; if (rdata0 !== 32'hA500_0040) begin nerr++; $display("FAIL single_data: got %h expected a5000040", rdata0); end
    nvec++; if (cen0 !== 1'b1) begin nerr++; $display("FAIL single_cen_idle: got %b expected 1", cen0); end
    step();
    nvec++; if (rdata0 !== 32'h0) begin nerr++; $display("FAIL single_data_idle: got %h expected 0", rdata0); end
  endtask

  task automatic test_wrap4();
    logic [31:0] addrs [4];
    logic [31:0] exp_d [4];
    addrs = '{32'h108, 32'h10C, 32'h100, 32'h104};
    exp_d = '{32'hA500_0042, 32'hA500_0043, 32'hA500_0040, 32'hA500_0041};
    drive(3'b010, addrs[0], HTRANS_NONSEQ, 1'b0, HSIZE_WORD, HBURST_WRAP4);
    #1;
    nvec++; if (cen1 !== 1'b0) begin nerr++; $display("FAIL wrap_cen0: got %b expected 0", cen1); end
    step();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) drive(3'b010, addrs[k+1], HTRANS_SEQ, 1'b0, HSIZE_WORD, HBURST_WRAP4);
      else bus_idle();
      #1;
      for (int w = 0; w < 2; w++) begin
        nvec++; if (rdy1 !== 1'b0) begin nerr++; $display("FAIL wrap_wait beat %0d: got %b expected 0", k, rdy1); end
        nvec++; if (cen1 !== 1'b1) begin nerr++; $display("FAIL wrap_wait_cen beat %0d: got %b expected 1", k, cen1); end
        step();
      end
      nvec++; if (rdy1 !== 1'b1) begin nerr++; $display("FAIL wrap_rdy beat %0d: got %b expected 1", k, rdy1); end
      nvec++; if (rdata1 !== exp_d[k]) begin nerr++; $display("FAIL wrap_data beat %0d: got %h expected %h", k, rdata1, exp_d[k]); end
      if (k < 3) begin
        nvec++; if (maddr1 !== addrs[k+1][13:2]) begin nerr++; $display("FAIL wrap_maddr beat %0d: got %h expected %h", k + 1, maddr1, addrs[k+1][13:2]); end
      end
      step();
    end
    nvec++; if (rdata1 !== 32'h0) begin nerr++; $display("FAIL wrap_end_data: got %h expected 0", rdata1); end
  endtask

  task automatic test_incr8();
    drive(3'b001, 32'h200, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, HBURST_INCR8);
    #1;
    step();
    for (int k = 0; k < 8; k++) begin
      if (k < 7) drive(3'b001, 32'h200 + 32'(4 * (k + 1)), HTRANS_SEQ, 1'b0, HSIZE_WORD, HBURST_INCR8);
      else bus_idle();
      #1;
      nvec++; if (rdy0 !== 1'b1) begin nerr++; $display("FAIL incr8_rdy beat %0d: got %b expected 1", k, rdy0); end
      nvec++; if (rdata0 !== 32'hA500_0080 + 32'(k)) begin nerr++; $display("FAIL incr8_data beat %0d: got %h expected %h", k, rdata0, 32'hA500_0080 + 32'(k)); end
      nvec++; if (cen0 !== (k == 7)) begin nerr++; $display("FAIL incr8_cen beat %0d: got %b expected %b", k, cen0, k == 7); end
      step();
    end
  endtask

  task automatic test_write();
    drive(3'b001, 32'h10, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, HBURST_SINGLE);
    #1;
    nvec++; if (cen0 !== 1'b1) begin nerr++; $display("FAIL write_cen: got %b expected 1", cen0); end
    step();
    bus_idle();
    #1;
`ifdef IMEM_ERR_EN
    nvec++; if (rdy0 !== 1'b0 || resp0 !== 1'b1) begin nerr++; $display("FAIL write_err1: got rdy=%b resp=%b expected rdy=0 resp=1", rdy0, resp0); end
    nvec++; if (cen0 !== 1'b1) begin nerr++; $display("FAIL write_err1_cen: got %b expected 1", cen0); end
    step();
    drive(3'b001, 32'h20, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, HBURST_SINGLE);
    #1;
    nvec++; if (rdy0 !== 1'b1 || resp0 !== 1'b1) begin nerr++; $display("FAIL write_err2: got rdy=%b resp=%b expected rdy=1 resp=1", rdy0, resp0); end
    nvec++; if (cen0 !== 1'b0) begin nerr++; $display("FAIL err2_accept_cen: got %b expected 0", cen0); end
    step();
    bus_idle();
    #1;
    nvec++; if (resp0 !== 1'b0) begin nerr++; $display("FAIL err2_next_resp: got %b expected 0", resp0); end
    nvec++; if (rdata0 !== 32'hA500_0008) begin nerr++; $display("FAIL err2_next_data: got %h expected a5000008", rdata0); end
`else
    nvec++; if (rdy0 !== 1'b1 || resp0 !== 1'b0) begin nerr++; $display("FAIL write_okay: got rdy=%b resp=%b expected rdy=1 resp=0", rdy0, resp0); end
    nvec++; if (rdata0 !== 32'h0) begin nerr++; $display("FAIL write_rdata: got %h expected 0", rdata0); end
    nvec++; if (cen0 !== 1'b1) begin nerr++; $display("FAIL write_cen_after: got %b expected 1", cen0); end
`endif
    step();
  endtask

  task automatic test_odd_read(input logic [31:0] a, input logic [2:0] sz,
                               input logic [11:0] exp_idx, input logic [31:0] exp_data);
    drive(3'b001, a, HTRANS_NONSEQ, 1'b0, sz, HBURST_SINGLE);
    #1;
`ifdef IMEM_ERR_EN
    nvec++; if (cen0 !== 1'b1) begin nerr++; $display("FAIL odd_cen %h: got %b expected 1", a, cen0); end
    step();
    bus_idle();
    #1;
    nvec++; if (rdy0 !== 1'b0 || resp0 !== 1'b1) begin nerr++; $display("FAIL odd_err1 %h: got rdy=%b resp=%b expected rdy=0 resp=1", a, rdy0, resp0); end
    step();
    nvec++; if (rdy0 !== 1'b1 || resp0 !== 1'b1) begin nerr++; $display("FAIL odd_err2 %h: got rdy=%b resp=%b expected rdy=1 resp=1", a, rdy0, resp0); end
`else
    nvec++; if (cen0 !== 1'b0) begin nerr++; $display("FAIL odd_cen %h: got %b expected 0", a, cen0); end
    nvec++; if (maddr0 !== exp_idx) begin nerr++; $display("FAIL odd_maddr %h: got %h expected %h", a, maddr0, exp_idx); end
    step();
    bus_idle();
    #1;
    nvec++; if (rdy0 !== 1'b1 || resp0 !== 1'b0) begin nerr++; $display("FAIL odd_rdy %h: got rdy=%b resp=%b expected rdy=1 resp=0", a, rdy0, resp0); end
    nvec++; if (rdata0 !== exp_data) begin nerr++; $display("FAIL odd_data %h: got %h expected %h", a, rdata0, exp_data); end
`endif
    step();
  endtask

  task automatic test_reset_mid_wait();
    drive(3'b100, 32'h30, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, HBURST_SINGLE);
    #1;
    step();
    bus_idle();
    #1;
    nvec++; if (rdy2 !== 1'b0) begin nerr++; $display("FAIL rstw_wait: got %b expected 0", rdy2); end
    rst = 1'b1;
    #1;
    nvec++; if (rdy2 !== 1'b1) begin nerr++; $display("FAIL rstw_rdy: got %b expected 1", rdy2); end
    nvec++; if (rdata2 !== 32'h0) begin nerr++; $display("FAIL rstw_rdata: got %h expected 0", rdata2); end
    nvec++; if (resp2 !== 1'b0) begin nerr++; $display("FAIL rstw_resp: got %b expected 0", resp2); end
    #1 rst = 1'b0;
    step();
    drive(3'b100, 32'h44, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, HBURST_SINGLE);
    #1;
    nvec++; if (cen2 !== 1'b0) begin nerr++; $display("FAIL rstw_next_cen: got %b expected 0", cen2); end
    nvec++; if (maddr2 !== 12'h011) begin nerr++; $display("FAIL rstw_next_maddr: got %h expected 011", maddr2); end
    step();
    bus_idle();
    #1;
    for (int w = 0; w < 3; w++) begin
      nvec++; if (rdy2 !== 1'b0) begin nerr++; $display("FAIL rstw_next_wait %0d: got %b expected 0", w, rdy2); end
      step();
    end
    nvec++; if (rdy2 !== 1'b1) begin nerr++; $display("FAIL rstw_next_rdy: got %b expected 1", rdy2); end
    nvec++; if (rdata2 !== 32'hA500_0011) begin nerr++; $display("FAIL rstw_next_data: got %h expected a5000011", rdata2); end
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus_idle();
    test_reset();
    test_single();
    test_wrap4();
    test_incr8();
    test_write();
    test_odd_read(32'h4000, HSIZE_WORD, 12'h000, 32'hA500_0000);
    test_odd_read(32'h106, HSIZE_BYTE, 12'h041, 32'hA500_0041);
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ahb_imem_slave.md
AHB_IMEM_SLAVE -- requirements
Module: ahb_imem_slave

Interface
REQ-001 SHALL have parameter MEM_AW, default 12, word-address width of backing memory (4 KiW).
REQ-002 SHALL have parameter WAIT_STATES, default 0, HREADYOUT-low cycles inserted per data phase (0..15).
REQ-003 SHALL have port HCLK  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port HRESET  in  1  asynchronous active-high reset.
REQ-005 SHALL have ports HSEL in 1, HADDR in 32, HTRANS in 2, HWRITE in 1, HSIZE in 3, HBURST in 3 and HREADY in 1 (bus-level ready) as AHB-Lite slave inputs.
REQ-006 SHALL have ports HRDATA out 32, HREADYOUT out 1 and HRESP out 1 as AHB-Lite slave outputs.
REQ-007 SHALL have ports mem_cen out 1 (active-low), mem_addr out MEM_AW and mem_dout in 32 for a synchronous single-port read memory with 1-cycle latency.

Function
REQ-008 SHALL accept a transfer only when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ; IDLE and BUSY give a zero-wait OKAY.
REQ-009 SHALL, on acceptance, drive mem_cen=0 and mem_addr=HADDR[MEM_AW+1:2] in the same cycle; mem_cen SHALL be 1 in every other cycle.
REQ-010 SHALL implement the FSM IDLE, WAIT, DATA, ERR1, ERR2; accept goes to WAIT if WAIT_STATES>0, else to DATA.
REQ-011 SHALL, in WAIT, hold HREADYOUT=0 and decrement a counter loaded with WAIT_STATES, entering DATA when it reaches 1.
REQ-012 SHALL, in DATA, drive HREADYOUT=1, HRESP=OKAY and HRDATA=mem_dout; HRDATA SHALL be 0 outside DATA.
REQ-013 SHALL, in the DATA cycle, treat a new accepted address phase as pipelined and go straight to WAIT/DATA with no idle bubble; otherwise it SHALL go to IDLE.
REQ-014 SHALL give SEQ beats of INCR, INCR4/8/16 and WRAP4/8/16 bursts the same timing as NONSEQ and use HADDR as presented, so a wrap needs no internal address arithmetic.
REQ-015 SHALL give read latency address-to-data of 1+WAIT_STATES cycles, i.e. one word per cycle sustained at WAIT_STATES=0.
REQ-016 SHALL discard the upper HADDR bits [31:MEM_AW+2] when the error feature is compiled out, so addresses wrap modulo the memory size.
REQ-017 SHALL ignore HBURST apart from pass-through and SHALL not track beat counts.

Reset
REQ-018 SHALL, on HRESET, set state=IDLE, counter=0, HREADYOUT=1, HRESP=0, HRDATA=0 and mem_cen=1, with mem_addr undefined-safe at 0.
REQ-019 SHALL, when HRESET asserts mid-burst or mid-wait, abandon the transfer immediately and start the first post-reset transfer from IDLE.

Configuration
REQ-020 SHALL, with IMEM_ERR_EN defined, answer writes, HSIZE other than word, HADDR[1:0]!=0, or HADDR at or above 4*2^MEM_AW with the two-cycle ERROR response.
REQ-021 SHALL drive that ERROR response as ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1), with no memory access (mem_cen=1).
REQ-022 SHALL, in ERR2, accept a new address phase like DATA does (an aborted burst after ERROR is legal).
REQ-023 SHALL, without IMEM_ERR_EN, omit ERR1/ERR2, treat writes as zero-wait OKAY no-ops, and treat misaligned or sub-word reads as the containing aligned word.

Structure
REQ-024 SHALL take the HTRANS encodings, HBURST/HSIZE encodings, HRESP OKAY/ERROR and the FSM state enum from shared package ahb_pkg.
REQ-025 SHALL be a single module with no sub-modules, the wait counter being inline.

Verification
REQ-026 SHALL cover: WAIT_STATES=0, NONSEQ 0x100 -> mem_cen low that cycle, next cycle HREADYOUT=1 and HRDATA=mem[0x40].
REQ-027 SHALL cover: WAIT_STATES=2, WRAP4 from 0x0000_0108 -> beats 0x108,0x10C,0x100,0x104, each with 2 low HREADYOUT cycles, data in order.
REQ-028 SHALL cover: WAIT_STATES=0, INCR8 from 0x200 with no BUSY -> 8 consecutive HREADYOUT=1 cycles, data mem[0x80..0x87].
REQ-029 SHALL cover, with IMEM_ERR_EN: HWRITE=1 at 0x10 -> HRESP=1/HREADYOUT=0 then HRESP=1/HREADYOUT=1, mem_cen stays 1.
REQ-030 SHALL cover, with IMEM_ERR_EN and MEM_AW=12: read at 0x4000 -> ERROR; without it -> data mem[0x000].
REQ-031 SHALL cover: HRESET pulsed during a WAIT cycle of a WAIT_STATES=3 read -> HREADYOUT=1, HRDATA=0 at once, next NONSEQ served normally.
